// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the ID stage of the core and the pipeline hazard controller.
// The core side (master) drives the ID instruction fields; the controller (slave) returns stall/flush/forwarding.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              fs_valid;
    logic [REG_AW-1:0] ds_rs1;
    logic [REG_AW-1:0] ds_rs2;
    logic              ds_rs1_used;
    logic              ds_rs2_used;
    logic [REG_AW-1:0] ds_rd;
    logic              ds_we;
    logic              ds_is_load;
    logic              br_taken;

    logic              fs_allowin;
    logic              ds_flush;
    logic              ds_valid;
    logic              es_valid;
    logic              ms_valid;
    logic              ws_valid;
    logic              ds_stall;
    logic [1:0]        fwd_rs1;
    logic [1:0]        fwd_rs2;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_we;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output fs_valid, ds_rs1, ds_rs2, ds_rs1_used, ds_rs2_used,
               ds_rd, ds_we, ds_is_load, br_taken,
        input  fs_allowin, ds_flush, ds_valid, es_valid, ms_valid, ws_valid,
               ds_stall, fwd_rs1, fwd_rs2, wb_rd, wb_we, stall_cnt, flush_cnt
    );

    modport slave (
        input  fs_valid, ds_rs1, ds_rs2, ds_rs1_used, ds_rs2_used,
               ds_rd, ds_we, ds_is_load, br_taken,
        output fs_allowin, ds_flush, ds_valid, es_valid, ms_valid, ws_valid,
               ds_stall, fwd_rs1, fwd_rs2, wb_rd, wb_we, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage core: tracks EX/MEM/WB occupancy and destinations,
// and produces load-use stall, wrong-path flush, ID operand forwarding selects and bring-up counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    logic              ds_valid;
    logic              es_valid, ms_valid, ws_valid;
    logic [REG_AW-1:0] es_rd, ms_rd, ws_rd;
    logic              es_we, ms_we, ws_we;
    logic              es_load;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    logic              es_hit1, ms_hit1, ws_hit1;
    logic              es_hit2, ms_hit2, ws_hit2;
    logic              ds_stall, ds_flush;
    logic [1:0]        fwd_rs1, fwd_rs2;

    // A stage can supply an operand only if it will really write a non-zero register.
    function automatic logic hit(input logic v, input logic we,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] rs);
        return v && we && (rd != '0) && (rd == rs);
    endfunction

    assign es_hit1 = hit(es_valid, es_we, es_rd, bus.ds_rs1);
    assign ms_hit1 = hit(ms_valid, ms_we, ms_rd, bus.ds_rs1);
    assign ws_hit1 = hit(ws_valid, ws_we, ws_rd, bus.ds_rs1);
    assign es_hit2 = hit(es_valid, es_we, es_rd, bus.ds_rs2);
    assign ms_hit2 = hit(ms_valid, ms_we, ms_rd, bus.ds_rs2);
    assign ws_hit2 = hit(ws_valid, ws_we, ws_rd, bus.ds_rs2);

    assign ds_stall = ds_valid && es_load &&
                      ((bus.ds_rs1_used && es_hit1) || (bus.ds_rs2_used && es_hit2));
    // Branch outcome is untrustworthy while its operands are still being loaded.
    assign ds_flush = ds_valid && bus.br_taken && !ds_stall;

    always_comb begin
        fwd_rs1 = 2'b00;
        fwd_rs2 = 2'b00;
        if (bus.ds_rs1_used) begin
            if (es_hit1)      fwd_rs1 = 2'b01;
            else if (ms_hit1) fwd_rs1 = 2'b10;
            else if (ws_hit1) fwd_rs1 = 2'b11;
        end
        if (bus.ds_rs2_used) begin
            if (es_hit2)      fwd_rs2 = 2'b01;
            else if (ms_hit2) fwd_rs2 = 2'b10;
            else if (ws_hit2) fwd_rs2 = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ds_valid  <= 1'b0;
            es_valid  <= 1'b0;
            ms_valid  <= 1'b0;
            ws_valid  <= 1'b0;
            es_rd     <= '0;
            ms_rd     <= '0;
            ws_rd     <= '0;
            es_we     <= 1'b0;
            ms_we     <= 1'b0;
            ws_we     <= 1'b0;
            es_load   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ds_stall)
                ds_valid <= bus.fs_valid && !ds_flush;

            // A stall holds ID and injects a bubble so the load reaches MEM before its consumer reads.
            if (ds_stall) begin
                es_valid <= 1'b0;
                es_rd    <= '0;
                es_we    <= 1'b0;
                es_load  <= 1'b0;
            end else begin
                es_valid <= ds_valid;
                es_rd    <= bus.ds_rd;
                es_we    <= bus.ds_we;
                es_load  <= bus.ds_is_load;
            end

            ms_valid <= es_valid;
            ms_rd    <= es_rd;
            ms_we    <= es_we;
            ws_valid <= ms_valid;
            ws_rd    <= ms_rd;
            ws_we    <= ms_we;

            if (ds_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ds_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.fs_allowin = !ds_stall;
    assign bus.ds_stall   = ds_stall;
    assign bus.ds_flush   = ds_flush;
    assign bus.ds_valid   = ds_valid;
    assign bus.es_valid   = es_valid;
    assign bus.ms_valid   = ms_valid;
    assign bus.ws_valid   = ws_valid;
    assign bus.fwd_rs1    = fwd_rs1;
    assign bus.fwd_rs2    = fwd_rs2;
    assign bus.wb_rd      = ws_rd;
    assign bus.wb_we      = ws_valid && ws_we;
    assign bus.stall_cnt  = stall_cnt;
    assign bus.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expectations are queued as each cycle's inputs are driven
// and drained against the DUT shortly after, with a narrow-counter copy sharing the same inputs.
module tb_pipe_hazard_ctrl;

    typedef enum int {
        S_ALLOWIN, S_FLUSH, S_DSV, S_ESV, S_MSV, S_WSV, S_STALL,
        S_FWD1, S_FWD2, S_WBRD, S_WBWE, S_SCNT, S_FCNT, S_SATCNT
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  sat_bus ();

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus)
    );

    assign sat_bus.fs_valid    = bus.fs_valid;
    assign sat_bus.ds_rs1      = bus.ds_rs1;
    assign sat_bus.ds_rs2      = bus.ds_rs2;
    assign sat_bus.ds_rs1_used = bus.ds_rs1_used;
    assign sat_bus.ds_rs2_used = bus.ds_rs2_used;
    assign sat_bus.ds_rd       = bus.ds_rd;
    assign sat_bus.ds_we       = bus.ds_we;
    assign sat_bus.ds_is_load  = bus.ds_is_load;
    assign sat_bus.br_taken    = bus.br_taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic fs, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic we, input logic ld, input logic br);
        @(negedge clk);
        bus.fs_valid    = fs;
        bus.ds_rs1      = rs1;
        bus.ds_rs2      = rs2;
        bus.ds_rs1_used = u1;
        bus.ds_rs2_used = u2;
        bus.ds_rd       = rd;
        bus.ds_we       = we;
        bus.ds_is_load  = ld;
        bus.br_taken    = br;
    endtask

    task automatic expectVal(input string tag, input sel_e sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = 16'(val);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_ALLOWIN: obs = 16'(bus.fs_allowin);
                S_FLUSH:   obs = 16'(bus.ds_flush);
                S_DSV:     obs = 16'(bus.ds_valid);
                S_ESV:     obs = 16'(bus.es_valid);
                S_MSV:     obs = 16'(bus.ms_valid);
                S_WSV:     obs = 16'(bus.ws_valid);
                S_STALL:   obs = 16'(bus.ds_stall);
                S_FWD1:    obs = 16'(bus.fwd_rs1);
                S_FWD2:    obs = 16'(bus.fwd_rs2);
                S_WBRD:    obs = 16'(bus.wb_rd);
                S_WBWE:    obs = 16'(bus.wb_we);
                S_SCNT:    obs = bus.stall_cnt;
                S_FCNT:    obs = bus.flush_cnt;
                default:   obs = 16'(sat_bus.stall_cnt);
            endcase
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.fs_valid = 0; bus.ds_rs1 = 0; bus.ds_rs2 = 0; bus.ds_rs1_used = 0;
        bus.ds_rs2_used = 0; bus.ds_rd = 0; bus.ds_we = 0; bus.ds_is_load = 0; bus.br_taken = 0;
        repeat (2) @(posedge clk);

        // Power-on reset state, then a back-to-back RAW chain on x3
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        expectVal("por_allowin", S_ALLOWIN, 1); expectVal("por_dsv", S_DSV, 0);
        expectVal("por_esv", S_ESV, 0);         expectVal("por_msv", S_MSV, 0);
        expectVal("por_wsv", S_WSV, 0);         expectVal("por_stall", S_STALL, 0);
        expectVal("por_flush", S_FLUSH, 0);     expectVal("por_wbwe", S_WBWE, 0);
        expectVal("por_scnt", S_SCNT, 0);       expectVal("por_fcnt", S_FCNT, 0);
        expectVal("por_fwd1", S_FWD1, 0);
        checkOutput();
        applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
        expectVal("raw_dsv", S_DSV, 1); expectVal("raw_fwd1_first", S_FWD1, 0);
        expectVal("raw_stall_first", S_STALL, 0);
        checkOutput();
        applyStimulus(0, 3, 1, 1, 1, 4, 1, 0, 0);
        expectVal("raw_fwd1_ex", S_FWD1, 1); expectVal("raw_fwd2", S_FWD2, 0);
        expectVal("raw_stall", S_STALL, 0);  expectVal("raw_allowin", S_ALLOWIN, 1);
        expectVal("raw_esv", S_ESV, 1);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectVal("raw_msv", S_MSV, 1); expectVal("raw_dsv_drop", S_DSV, 0);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectVal("raw_wbrd3", S_WBRD, 3); expectVal("raw_wbwe3", S_WBWE, 1);
        expectVal("raw_wsv", S_WSV, 1);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectVal("raw_wbrd4", S_WBRD, 4); expectVal("raw_wbwe4", S_WBWE, 1);
        checkOutput();
        idleCycles(3);

        // Load-use: lw x5 then add x6,x5,x0
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0);
        expectVal("lu_nostall_load", S_STALL, 0);
        checkOutput();
        applyStimulus(1, 5, 0, 1, 1, 6, 1, 0, 0);
        expectVal("lu_stall", S_STALL, 1);      expectVal("lu_allowin", S_ALLOWIN, 0);
        expectVal("lu_noflush", S_FLUSH, 0);    expectVal("lu_scnt_pre", S_SCNT, 0);
        checkOutput();
        applyStimulus(0, 5, 0, 1, 1, 6, 1, 0, 0);
        expectVal("lu_stall_end", S_STALL, 0);  expectVal("lu_allowin_end", S_ALLOWIN, 1);
        expectVal("lu_bubble", S_ESV, 0);       expectVal("lu_dsv_held", S_DSV, 1);
        expectVal("lu_fwd1_mem", S_FWD1, 2);    expectVal("lu_fwd2_x0", S_FWD2, 0);
        expectVal("lu_scnt", S_SCNT, 1);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectVal("lu_scnt_hold", S_SCNT, 1); expectVal("lu_wbrd", S_WBRD, 5);
        expectVal("lu_wbwe", S_WBWE, 1);      expectVal("lu_dsv_drop", S_DSV, 0);
        checkOutput();
        idleCycles(3);

        // Taken branch kills the wrong-path fetch; the branch itself moves on to EX
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 1);
        expectVal("br_flush", S_FLUSH, 1); expectVal("br_stall", S_STALL, 0);
        expectVal("br_fcnt_pre", S_FCNT, 0);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expectVal("br_flush_idle", S_FLUSH, 0); expectVal("br_dsv", S_DSV, 0);
        expectVal("br_esv", S_ESV, 1);          expectVal("br_fcnt", S_FCNT, 1);
        checkOutput();
        idleCycles(3);

        // Branch depending on a load: flush held off during the stall, applied next cycle
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0, 1, 0, 8, 1, 1, 0);
        checkOutput();
        applyStimulus(1, 8, 1, 1, 1, 0, 0, 0, 1);
        expectVal("sb_stall", S_STALL, 1); expectVal("sb_flush_masked", S_FLUSH, 0);
        expectVal("sb_scnt_pre", S_SCNT, 1);
        checkOutput();
        applyStimulus(1, 8, 1, 1, 1, 0, 0, 0, 1);
        expectVal("sb_stall_end", S_STALL, 0); expectVal("sb_flush", S_FLUSH, 1);
        expectVal("sb_fwd1", S_FWD1, 2);       expectVal("sb_fwd2", S_FWD2, 0);
        expectVal("sb_fcnt_pre", S_FCNT, 1);   expectVal("sb_scnt", S_SCNT, 2);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectVal("sb_fcnt", S_FCNT, 2); expectVal("sb_dsv", S_DSV, 0);
        checkOutput();
        idleCycles(3);

        // Forwarding priority with x7 written in EX, MEM and WB
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 0, 1, 0, 7, 1, 0, 0);
            checkOutput();
        end
        applyStimulus(0, 7, 7, 1, 1, 9, 1, 0, 0);
        expectVal("pri_fwd1_ex", S_FWD1, 1); expectVal("pri_fwd2_ex", S_FWD2, 1);
        expectVal("pri_stall", S_STALL, 0);
        checkOutput();
        applyStimulus(0, 7, 7, 1, 0, 0, 0, 0, 0);
        expectVal("pri_fwd1_mem", S_FWD1, 2); expectVal("pri_fwd2_unused", S_FWD2, 0);
        checkOutput();
        applyStimulus(0, 7, 9, 1, 1, 0, 0, 0, 0);
        expectVal("pri_fwd1_wb", S_FWD1, 3); expectVal("pri_fwd2_mem", S_FWD2, 2);
        checkOutput();
        idleCycles(3);

        // x0 is never forwarded and never stalls, even behind a load to x0
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0, 1, 0, 0, 1, 1, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, 0);
        expectVal("x0_stall_load", S_STALL, 0); expectVal("x0_fwd1_load", S_FWD1, 0);
        checkOutput();
        applyStimulus(0, 0, 0, 1, 1, 10, 1, 0, 0);
        expectVal("x0_stall", S_STALL, 0); expectVal("x0_fwd1", S_FWD1, 0);
        expectVal("x0_fwd2", S_FWD2, 0);
        checkOutput();
        idleCycles(3);

        // Mid-stream reset with every stage full and a load-use stall pending
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0, 1, 0, 11, 1, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0, 1, 0, 11, 1, 0, 0);
        checkOutput();
        applyStimulus(1, 1, 0, 1, 0, 12, 1, 1, 0);
        checkOutput();
        applyStimulus(1, 12, 0, 1, 0, 13, 1, 0, 0);
        rst = 1'b1;
        expectVal("mr_dsv_full", S_DSV, 1); expectVal("mr_esv_full", S_ESV, 1);
        expectVal("mr_msv_full", S_MSV, 1); expectVal("mr_wsv_full", S_WSV, 1);
        expectVal("mr_stall_pending", S_STALL, 1);
        expectVal("mr_scnt_pre", S_SCNT, 2); expectVal("mr_fcnt_pre", S_FCNT, 2);
        checkOutput();
        applyStimulus(1, 12, 0, 1, 0, 13, 1, 0, 0);
        expectVal("mr_dsv_inreset", S_DSV, 0);
        checkOutput();
        applyStimulus(0, 12, 0, 1, 0, 13, 1, 0, 0);
        rst = 1'b0;
        expectVal("mr_dsv", S_DSV, 0);          expectVal("mr_esv", S_ESV, 0);
        expectVal("mr_msv", S_MSV, 0);          expectVal("mr_wsv", S_WSV, 0);
        expectVal("mr_allowin", S_ALLOWIN, 1);  expectVal("mr_stall", S_STALL, 0);
        expectVal("mr_scnt", S_SCNT, 0);        expectVal("mr_fcnt", S_FCNT, 0);
        expectVal("mr_wbwe", S_WBWE, 0);        expectVal("mr_fwd1", S_FWD1, 0);
        expectVal("mr_satcnt", S_SATCNT, 0);
        checkOutput();
        idleCycles(3);

        // Five load-use stalls: wide counter reaches 5, 2-bit counter pins at 3
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 13, 1, 1, 0);
            expectVal("sat_nostall_load", S_STALL, 0);
            checkOutput();
            applyStimulus(1, 13, 0, 1, 0, 14, 1, 0, 0);
            expectVal("sat_stall", S_STALL, 1);
            expectVal("sat_scnt_run", S_SCNT, i);
            expectVal("sat_satcnt_run", S_SATCNT, (i > 3) ? 3 : i);
            checkOutput();
            applyStimulus(1, 13, 0, 1, 0, 14, 1, 0, 0);
            expectVal("sat_fwd1", S_FWD1, 2);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expectVal("sat_scnt_final", S_SCNT, 5);
        expectVal("sat_satcnt_final", S_SATCNT, 3);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
